pps_generator: RTL and testbench

PPS_GENERATOR -- requirements
Module: pps_generator

---
 rtl/pps_pkg.sv | 18 +
 rtl/pps_edge_sync.sv | 37 +++
 rtl/pps_generator.sv | 115 +++++++++++
 tb/tb_pps_generator.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/pps_pkg.sv
// Shared types and constants for the PPS generator.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: FSM state encoding and the minimum legal period length.
package pps_pkg;

  // Generator states. IDLE is the reset/disabled state.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } pps_state_t;

  // A period needs at least one high and one low cycle to be meaningful.
  localparam int MIN_PERIOD = 2;

endpackage

// File: rtl/pps_edge_sync.sv
// Two-flop synchronizer followed by a registered rising-edge detector.
// Latency: 3 clk cycles from an async_in rising edge to the rise strobe.
// Backpressure: none; rise is a one-cycle strobe that is never held.
//
// Ports:
//   clk      - rising-edge clock
//   rst_n    - asynchronous active-low reset, clears all flops
//   async_in - asynchronous input level
//   rise     - one-cycle strobe on each synchronized rising edge
module pps_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise
);

  logic meta;
  logic sync;
  logic sync_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta   <= 1'b0;
      sync   <= 1'b0;
      sync_d <= 1'b0;
      rise   <= 1'b0;
    end else begin
      meta   <= async_in;
      sync   <= meta;
      sync_d <= sync;
      // Registered so that the strobe itself is glitch-free and lands
      // a fixed three cycles after the input edge.
      rise   <= sync & ~sync_d;
    end
  end

endmodule

// File: rtl/pps_generator.sv
// Programmable pulse-per-second generator with optional external re-phasing.
// Latency: all outputs registered, 1 cycle after the sampled inputs; ext_pps 3 cycles to ext_rise.
// Backpressure: none; free-running once enabled, enable=0 returns to idle.
//
// Ports:
//   clk, rst_n  - rising-edge clock, asynchronous active-low reset
//   enable      - 1 runs the generator, 0 forces IDLE
//   period_cfg  - clk cycles per period (values below 2 behave as 2)
//   width_cfg   - pps_out high time in cycles (clamped to period-1)
//   align_en    - allow ext_pps rising edges to restart the period
//   ext_pps     - asynchronous external reference pulse
//   pps_out     - generated PPS level
//   pps_tick    - one-cycle strobe at every period start
//   sec_count   - periods started since enable (wraps silently)
//   phase       - cycle index within the current period
module pps_generator
  import pps_pkg::*;
#(
  parameter int COUNT_WIDTH = 32,
  parameter int SEC_WIDTH   = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic [COUNT_WIDTH-1:0] period_cfg,
  input  logic [COUNT_WIDTH-1:0] width_cfg,
  input  logic                   align_en,
  input  logic                   ext_pps,
  output logic                   pps_out,
  output logic                   pps_tick,
  output logic [SEC_WIDTH-1:0]   sec_count,
  output logic [COUNT_WIDTH-1:0] phase
);

  localparam logic [COUNT_WIDTH-1:0] ONE   = COUNT_WIDTH'(1);
  localparam logic [COUNT_WIDTH-1:0] MIN_P = COUNT_WIDTH'(MIN_PERIOD);
  localparam logic [SEC_WIDTH-1:0]   SEC_1 = SEC_WIDTH'(1);

  pps_state_t             state;
  logic [COUNT_WIDTH-1:0] shadow_period;
  logic [COUNT_WIDTH-1:0] shadow_width;
  logic                   ext_rise;

  logic [COUNT_WIDTH-1:0] eff_period;
  logic [COUNT_WIDTH-1:0] eff_width;
  logic [COUNT_WIDTH-1:0] new_period;
  logic [COUNT_WIDTH-1:0] new_width;
  logic [COUNT_WIDTH-1:0] phase_inc;
  logic                   period_end;
  logic                   period_start;

  function automatic logic [COUNT_WIDTH-1:0] clamp_period(input logic [COUNT_WIDTH-1:0] p);
    return (p < MIN_P) ? MIN_P : p;
  endfunction

  // Width can never cover the whole period, so there is always a low cycle.
  function automatic logic [COUNT_WIDTH-1:0] clamp_width(input logic [COUNT_WIDTH-1:0] w,
                                                         input logic [COUNT_WIDTH-1:0] p);
    return (w > p - ONE) ? (p - ONE) : w;
  endfunction

  pps_edge_sync u_ext_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (ext_pps),
    .rise     (ext_rise)
  );

  always_comb begin
    // Running values come from the shadows; the values for a new period
    // come straight from the cfg inputs because the shadows reload on
    // the same edge.
    eff_period   = clamp_period(shadow_period);
    eff_width    = clamp_width(shadow_width, eff_period);
    new_period   = clamp_period(period_cfg);
    new_width    = clamp_width(width_cfg, new_period);
    phase_inc    = phase + ONE;
    period_end   = (phase >= eff_period - ONE);
    // An alignment edge on the last cycle merges with the natural wrap.
    period_start = (state == IDLE) || period_end || (align_en && ext_rise);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      shadow_period <= '0;
      shadow_width  <= '0;
      phase         <= '0;
      sec_count     <= '0;
      pps_tick      <= 1'b0;
      pps_out       <= 1'b0;
    end else if (!enable) begin
      state     <= IDLE;
      phase     <= '0;
      sec_count <= '0;
      pps_tick  <= 1'b0;
      pps_out   <= 1'b0;
    end else if (period_start) begin
      shadow_period <= period_cfg;
      shadow_width  <= width_cfg;
      phase         <= '0;
      pps_tick      <= 1'b1;
      sec_count     <= (state == IDLE) ? SEC_1 : sec_count + SEC_1;
      // Zero width skips HIGH entirely.
      state         <= (new_width != '0) ? HIGH : LOW;
      pps_out       <= (new_width != '0);
    end else begin
      phase    <= phase_inc;
      pps_tick <= 1'b0;
      state    <= (phase_inc < eff_width) ? HIGH : LOW;
      pps_out  <= (phase_inc < eff_width);
    end
  end

endmodule

// File: tb/tb_pps_generator.sv
module tb_pps_generator;

  localparam int CW = 16;
  localparam int SW = 4;

  logic          clk;
  logic          rst_n;
  logic          enable;
  logic [CW-1:0] period_cfg;
  logic [CW-1:0] width_cfg;
  logic          align_en;
  logic          ext_pps;
  logic          pps_out;
  logic          pps_tick;
  logic [SW-1:0] sec_count;
  logic [CW-1:0] phase;

  int n_checks;
  int n_errors;

  // Reference model: "time since the current period began" plus the
  // parameters captured at that start.
  bit m_run;
  int m_elapsed;
  int m_p;
  int m_w;
  int m_sec;
  bit ext_hist [4];

  pps_generator #(.COUNT_WIDTH(CW), .SEC_WIDTH(SW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .period_cfg (period_cfg),
    .width_cfg  (width_cfg),
    .align_en   (align_en),
    .ext_pps    (ext_pps),
    .pps_out    (pps_out),
    .pps_tick   (pps_tick),
    .sec_count  (sec_count),
    .phase      (phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_run     = 1'b0;
    m_elapsed = 0;
    foreach (ext_hist[i]) ext_hist[i] = 1'b0;
  endtask

  task automatic start_period(input bit from_idle);
    m_sec     = from_idle ? 1 : (m_sec + 1) % (1 << SW);
    m_run     = 1'b1;
    m_p       = (int'(period_cfg) < 2) ? 2 : int'(period_cfg);
    m_w       = (int'(width_cfg) > m_p - 1) ? m_p - 1 : int'(width_cfg);
    m_elapsed = 0;
  endtask

  // Advance the model by one clock edge using the inputs present at it.
  task automatic model_edge();
    bit rise_seen;
    // A rising ext_pps sampled at edge n is acted on at edge n+3.
    rise_seen   = ext_hist[2] & ~ext_hist[3];
    ext_hist[3] = ext_hist[2];
    ext_hist[2] = ext_hist[1];
    ext_hist[1] = ext_hist[0];
    ext_hist[0] = ext_pps;
    if (!enable)                               m_run = 1'b0;
    else if (!m_run)                           start_period(1'b1);
    else if (m_elapsed == m_p - 1)             start_period(1'b0);
    else if (align_en && rise_seen)            start_period(1'b0);
    else                                       m_elapsed++;
  endtask

  task automatic check_outputs(input string pfx);
    check({pfx, "_pps_out"},  pps_out,   (m_run && m_elapsed < m_w) ? 1 : 0);
    check({pfx, "_pps_tick"}, pps_tick,  (m_run && m_elapsed == 0) ? 1 : 0);
    check({pfx, "_sec"},      sec_count, m_run ? m_sec : 0);
    check({pfx, "_phase"},    phase,     m_run ? m_elapsed : 0);
  endtask

  task automatic step(input string pfx);
    @(posedge clk);
    if (!rst_n) model_clear();
    else        model_edge();
    #1;
    check_outputs(pfx);
  endtask

  task automatic run(input string pfx, input int n);
    for (int i = 0; i < n; i++) step(pfx);
  endtask

  task automatic wait_elapsed(input string pfx, input int target);
    int k;
    k = 0;
    while (m_elapsed != target && k < 100) begin
      step(pfx);
      k++;
    end
    check({pfx, "_reached"}, (m_elapsed == target) ? 1 : 0, 1);
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    rst_n      = 1'b0;
    enable     = 1'b0;
    period_cfg = '0;
    width_cfg  = '0;
    align_en   = 1'b0;
    ext_pps    = 1'b0;
    model_clear();
    m_sec = 0;
    m_p   = 2;
    m_w   = 0;

    #2;
    check_outputs("reset");
    run("reset", 3);
    rst_n = 1'b1;
    run("idle", 3);

    // P=10, W=3: 3 high, 7 low, tick every 10.
    period_cfg = 16'd10;
    width_cfg  = 16'd3;
    enable     = 1'b1;
    run("p10w3", 35);

    // Zero width: level stays low, ticks continue.
    width_cfg = 16'd0;
    run("w0", 25);
    // Oversized width clamps to P-1.
    width_cfg = 16'd15;
    run("w15", 25);
    // Period of 1 behaves as 2.
    period_cfg = 16'd1;
    width_cfg  = 16'd1;
    run("p1", 10);

    // Period change mid-period only applies from the next start.
    period_cfg = 16'd10;
    width_cfg  = 16'd3;
    run("prep", 12);
    wait_elapsed("pchg", 4);
    period_cfg = 16'd20;
    run("pchg", 35);

    // Enable drop and restart.
    enable = 1'b0;
    run("dis", 4);
    period_cfg = 16'd10;
    enable     = 1'b1;
    run("reen", 13);

    // Alignment: edge at phase 2 restarts after phase 5.
    align_en = 1'b1;
    wait_elapsed("al2", 2);
    ext_pps = 1'b1;
    run("al2", 5);
    ext_pps = 1'b0;
    run("al2", 8);
    // Edge landing on the last cycle merges with the wrap.
    wait_elapsed("al9", 6);
    ext_pps = 1'b1;
    run("al9", 5);
    ext_pps = 1'b0;
    run("al9", 12);
    // Alignment disabled: edges ignored.
    align_en = 1'b0;
    wait_elapsed("noal", 1);
    ext_pps = 1'b1;
    run("noal", 6);
    ext_pps = 1'b0;
    run("noal", 6);

    // Async reset mid-HIGH at sec_count 7.
    for (int i = 0; i < 200 && !(m_sec == 7 && m_elapsed == 1); i++) step("to7");
    check("to7_reached", (m_sec == 7 && m_elapsed == 1) ? 1 : 0, 1);
    rst_n = 1'b0;
    #1;
    model_clear();
    check_outputs("rst_async");
    enable = 1'b0;
    run("rst_hold", 2);
    rst_n = 1'b1;
    run("rst_idle", 3);
    enable = 1'b1;
    run("restart", 12);

    // Randomized traffic; small periods make sec_count wrap.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) enable = ~enable;
      if (!enable && $urandom_range(0, 7) == 0) enable = 1'b1;
      if ($urandom_range(0, 14) == 0) period_cfg = CW'($urandom_range(0, 25));
      if ($urandom_range(0, 14) == 0) width_cfg  = CW'($urandom_range(0, 30));
      if ($urandom_range(0, 49) == 0) align_en   = ~align_en;
      if ($urandom_range(0, 5) == 0)  ext_pps    = ~ext_pps;
      step("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
